keypad_digit_loader: RTL and testbench

Sequential consumer of the keypad priority encoder's outputs (D, all_off) in the timer-control path. It debounces key presses and releases, then shifts each accepted BCD digit into a 4-digit MM:SS entry register. The register feeds the countdown timer. One digit is captured per physical press, and a key held across reset or enable is never captured.

---
 rtl/keypad_digit_loader_if.sv | 37 +++
 rtl/keypad_digit_loader.sv | 154 +++++++++++++++
 tb/tb_keypad_digit_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_digit_loader_if.sv
// ---------------------------------------------------------------------------
// keypad_digit_loader_if
//   Bundles the keypad-entry signals exchanged between the keypad priority
//   encoder / oven controller (master) and the digit loader (slave).
//
//   master -> slave : loadn (active-low entry enable), clear (sync clear),
//                     D (encoded digit), all_off (no key pressed)
//   slave -> master : sec_ones, sec_tens, min_ones, min_tens (BCD MM:SS),
//                     entry_count (digits entered, 0..4), digit_strobe
//                     (one-cycle pulse after a digit is shifted in),
//                     valid_time (entered time is loadable)
// ---------------------------------------------------------------------------
interface keypad_digit_loader_if;
  logic       loadn;
  logic       clear;
  logic [3:0] D;
  logic       all_off;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [2:0] entry_count;
  logic       digit_strobe;
  logic       valid_time;

  modport master (
    output loadn, clear, D, all_off,
    input  sec_ones, sec_tens, min_ones, min_tens,
    input  entry_count, digit_strobe, valid_time
  );

  modport slave (
    input  loadn, clear, D, all_off,
    output sec_ones, sec_tens, min_ones, min_tens,
    output entry_count, digit_strobe, valid_time
  );
endinterface

// File: rtl/keypad_digit_loader.sv
// ---------------------------------------------------------------------------
// keypad_digit_loader
//   Debounces keypad presses/releases and shifts each accepted BCD digit into
//   a 4-digit MM:SS entry register that feeds the countdown timer. One digit
//   per physical press; a key held across reset or loadn is never captured.
//
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   kp    : keypad_digit_loader_if.slave (inputs loadn/clear/D/all_off,
//           outputs digits, entry_count, digit_strobe, valid_time)
//
//   Parameters: DEBOUNCE_CYCLES (>= 1) consecutive stable samples to accept a
//   press or release; DB_W must be wide enough to hold DEBOUNCE_CYCLES.
// ---------------------------------------------------------------------------
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3
) (
  input logic                  clk,
  input logic                  reset,
  keypad_digit_loader_if.slave kp
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_DB     = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam logic [DB_W-1:0] DB_TARGET  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [2:0]      MAX_DIGITS = 3'd4;
  localparam logic [3:0]      MAX_BCD    = 4'd9;
  localparam logic [3:0]      MAX_STENS  = 4'd5;

  state_e          state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d;
  // Index 0 = sec_ones ... 3 = min_tens, so a left shift moves digits up.
  logic [3:0][3:0] digits_q, digits_d;
  logic [2:0]      count_q, count_d;
  logic            strobe_q, strobe_d;
  logic            take_digit;

  // Saturating increment: the debounce counter never wraps.
  assign cnt_inc = (cnt_q >= DB_TARGET) ? DB_TARGET : cnt_q + DB_ONE;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    digits_d   = digits_q;
    count_d    = count_q;
    strobe_d   = 1'b0;
    take_digit = 1'b0;

    case (state_q)
      IDLE: begin
        if (!kp.all_off) begin
          cand_d  = kp.D;
          cnt_d   = DB_ONE;
          state_d = (DB_ONE >= DB_TARGET) ? CAPTURE : PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (kp.all_off) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (kp.D != cand_q) begin
          // Code changed mid-debounce: restart on the new candidate.
          cand_d = kp.D;
          cnt_d  = DB_ONE;
          if (DB_ONE >= DB_TARGET) state_d = CAPTURE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DB_TARGET) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        take_digit = (cand_q <= MAX_BCD) && (count_q < MAX_DIGITS);
        cnt_d      = '0;
        state_d    = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (kp.all_off) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DB_TARGET) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
    endcase

    // Entry disabled: park in WAIT_RELEASE so a key held through the enable
    // edge needs a fresh debounced release before it can be captured.
    if (kp.loadn) begin
      state_d    = WAIT_RELEASE;
      cnt_d      = '0;
      take_digit = 1'b0;
    end

    if (take_digit && !kp.clear) begin
      digits_d = {digits_q[2:0], cand_q};
      count_d  = count_q + 3'd1;
      strobe_d = 1'b1;
    end

    // clear overrides a same-cycle capture but leaves the FSM path alone.
    if (kp.clear) begin
      digits_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= WAIT_RELEASE;
      cnt_q    <= '0;
      cand_q   <= '0;
      digits_q <= '0;
      count_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

  assign kp.sec_ones     = digits_q[0];
  assign kp.sec_tens     = digits_q[1];
  assign kp.min_ones     = digits_q[2];
  assign kp.min_tens     = digits_q[3];
  assign kp.entry_count  = count_q;
  assign kp.digit_strobe = strobe_q;
  assign kp.valid_time   = (count_q != 3'd0) && (digits_q != '0) &&
                           (digits_q[1] <= MAX_STENS);

endmodule

// File: tb/tb_keypad_digit_loader.sv
// ---------------------------------------------------------------------------
// tb_keypad_digit_loader
//   Directed stimulus with hand-computed expectations. Each press expected to
//   produce a digit pushes {digits, entry_count, strobe cycle} into a queue;
//   a negedge monitor pops and compares whenever digit_strobe is high.
// ---------------------------------------------------------------------------
module tb_keypad_digit_loader;
  localparam int N = 4;

  typedef struct {
    logic [15:0] digits;  // {min_tens, min_ones, sec_tens, sec_ones}
    logic [2:0]  count;
    int          cyc;     // clock edge at which the digit is shifted in
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  keypad_digit_loader_if kp_if ();

  keypad_digit_loader #(
    .DEBOUNCE_CYCLES(N),
    .DB_W           (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] shown();
    return {kp_if.min_tens, kp_if.min_ones, kp_if.sec_tens, kp_if.sec_ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] digits,
                             input logic [2:0] count, input logic valid);
    check({tag, "_digits"}, shown(), digits);
    check({tag, "_count"}, kp_if.entry_count, count);
    check({tag, "_valid"}, kp_if.valid_time, valid);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset && kp_if.digit_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe with digits %h count %0d, expected no strobe (cyc %0d)",
                 shown(), kp_if.entry_count, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_digits", shown(), mon_e.digits);
        check("strobe_count", kp_if.entry_count, mon_e.count);
        check("strobe_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int rel);
    kp_if.D       = d;
    kp_if.all_off = 1'b0;
    tick(hold);
    kp_if.all_off = 1'b1;
    tick(rel);
  endtask

  // Clean press from IDLE: onset edge is cyc+1, digit shifts in N edges later.
  task automatic press_exp(input logic [3:0] d, input logic [15:0] digits, input logic [2:0] count);
    exp_t e;
    e.digits = digits;
    e.count  = count;
    e.cyc    = cyc + 1 + N;
    exp_q.push_back(e);
    press(d, 6, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset         = 1'b1;
    kp_if.loadn   = 1'b0;
    kp_if.clear   = 1'b0;
    kp_if.D       = 4'd0;
    kp_if.all_off = 1'b1;
    tick(3);
    check_state("reset", 16'h0000, 3'd0, 1'b0);
    check("reset_strobe", kp_if.digit_strobe, 1'b0);
    reset = 1'b0;
    tick(6);

    // Four digits, then saturation and clear.
    press_exp(4'd1, 16'h0001, 3'd1);
    press_exp(4'd2, 16'h0012, 3'd2);
    press_exp(4'd3, 16'h0123, 3'd3);
    press_exp(4'd0, 16'h1230, 3'd4);
    check_state("four_digits", 16'h1230, 3'd4, 1'b1);
    press(4'd7, 6, 6);
    check_state("saturated", 16'h1230, 3'd4, 1'b1);
    kp_if.clear = 1'b1;
    tick(1);
    kp_if.clear = 1'b0;
    check_state("cleared", 16'h0000, 3'd0, 1'b0);

    // Bouncing contact: 0/1 every 2 cycles, then stays closed.
    kp_if.D = 4'd5;
    for (int i = 0; i < 4; i++) begin
      kp_if.all_off = (i % 2 == 1);
      tick(2);
    end
    e.digits = 16'h0005; e.count = 3'd1; e.cyc = cyc + 1 + N;
    exp_q.push_back(e);
    kp_if.all_off = 1'b0;
    tick(8);
    kp_if.all_off = 1'b1;
    tick(6);

    // Code changes 5 -> 6 after two samples: count restarts at edge o+2.
    e.digits = 16'h0056; e.count = 3'd2; e.cyc = cyc + 1 + 6;
    exp_q.push_back(e);
    kp_if.D       = 4'd5;
    kp_if.all_off = 1'b0;
    tick(2);
    kp_if.D = 4'd6;
    tick(8);
    kp_if.all_off = 1'b1;
    tick(6);
    check_state("bounce", 16'h0056, 3'd2, 1'b1);

    // Key 9 held through reset: must not be captured until released.
    kp_if.D       = 4'd9;
    kp_if.all_off = 1'b0;
    reset         = 1'b1;
    tick(2);
    check_state("reset_held", 16'h0000, 3'd0, 1'b0);
    reset = 1'b0;
    tick(20);
    check_state("held_after_reset", 16'h0000, 3'd0, 1'b0);
    kp_if.all_off = 1'b1;
    tick(4);
    press_exp(4'd9, 16'h0009, 3'd1);

    // valid_time boundaries.
    kp_if.clear = 1'b1;
    tick(1);
    kp_if.clear = 1'b0;
    press_exp(4'd0, 16'h0000, 3'd1);
    check_state("zero_digit", 16'h0000, 3'd1, 1'b0);
    press_exp(4'd7, 16'h0007, 3'd2);
    check_state("zero_seven", 16'h0007, 3'd2, 1'b1);
    press_exp(4'd8, 16'h0078, 3'd3);
    check_state("sec_tens_7", 16'h0078, 3'd3, 1'b0);

    // loadn high during a press; key still held when loadn drops.
    kp_if.loadn   = 1'b1;
    kp_if.D       = 4'd3;
    kp_if.all_off = 1'b0;
    tick(3);
    kp_if.loadn = 1'b0;
    tick(8);
    kp_if.all_off = 1'b1;
    tick(6);
    check_state("loadn_block", 16'h0078, 3'd3, 1'b0);

    // clear lands on the CAPTURE edge of D=4; held key must not recapture.
    kp_if.D       = 4'd4;
    kp_if.all_off = 1'b0;
    tick(N);
    kp_if.clear = 1'b1;
    tick(1);
    kp_if.clear = 1'b0;
    tick(12);
    check_state("clear_capture", 16'h0000, 3'd0, 1'b0);
    kp_if.all_off = 1'b1;
    tick(6);
    press_exp(4'd4, 16'h0004, 3'd1);
    check_state("after_clear", 16'h0004, 3'd1, 1'b1);

    tick(3);
    check("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
